// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single memory port.
// Optional macro ARB_ROUND_ROBIN_EN switches collision handling from fixed data priority to alternating.
module mem_port_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [DATA_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [3:0]        d_byte_enable,
    input  logic [DATA_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [3:0]        mem_byte_enable,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t state, state_nxt;
    logic   d_req;
    logic   grant_d;

    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // last_d=1 means data was granted most recently; reset to "I last" so data wins first
    logic last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_d <= 1'b0;
        else if (state == IDLE && (i_read || d_req))
            last_d <= grant_d;
    end

    assign grant_d = d_req && (!i_read || !last_d);
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'h0;
        mem_address     = '0;
        mem_wdata       = '0;
        i_resp          = 1'b0;
        d_resp          = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d)
                    state_nxt = SERVE_D;
                else if (i_read)
                    state_nxt = SERVE_I;
            end
            SERVE_I: begin
                mem_read        = 1'b1;
                mem_byte_enable = 4'hF;
                mem_address     = i_address;
                if (mem_resp) begin
                    i_resp    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SERVE_D: begin
                // A simultaneous read+write is issued as a write only
                mem_write       = d_write;
                mem_read        = d_read & ~d_write;
                mem_byte_enable = d_byte_enable;
                mem_address     = d_address;
                mem_wdata       = d_wdata;
                if (mem_resp) begin
                    d_resp    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; collision order follows ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, leaving time to drive inputs before the next edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".mem_read"}, {31'b0, mem_read}, 32'h0);
        chk({tag, ".mem_write"}, {31'b0, mem_write}, 32'h0);
        chk({tag, ".mem_be"}, {28'b0, mem_byte_enable}, 32'h0);
        chk({tag, ".mem_address"}, mem_address, 32'h0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, ".i_resp"}, {31'b0, i_resp}, 32'h0);
        chk({tag, ".d_resp"}, {31'b0, d_resp}, 32'h0);
    endtask

    logic [2:0] exp_d;

    initial begin
        rst = 1'b1;
        i_read = 0; i_address = 0;
        d_read = 0; d_write = 0; d_byte_enable = 0; d_address = 0; d_wdata = 0;
        mem_rdata = 0; mem_resp = 1'b1;
        #12;
        chk_idle_outputs("reset");
        mem_resp = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single fetch, response after 3 serve cycles
        i_read = 1; i_address = 32'h60;
        #1;
        chk("fetch.pre_edge_read", {31'b0, mem_read}, 32'h0);
        tick();
        chk("fetch.mem_read", {31'b0, mem_read}, 32'h1);
        chk("fetch.mem_write", {31'b0, mem_write}, 32'h0);
        chk("fetch.mem_address", mem_address, 32'h60);
        chk("fetch.mem_be", {28'b0, mem_byte_enable}, 32'hF);
        chk("fetch.mem_wdata", mem_wdata, 32'h0);
        tick();
        tick();
        chk("fetch.held_read", {31'b0, mem_read}, 32'h1);
        chk("fetch.no_early_resp", {31'b0, i_resp}, 32'h0);
        mem_resp = 1; mem_rdata = 32'h13;
        #1;
        chk("fetch.i_resp", {31'b0, i_resp}, 32'h1);
        chk("fetch.i_rdata", i_rdata, 32'h13);
        chk("fetch.d_resp", {31'b0, d_resp}, 32'h0);
        tick();
        mem_resp = 0; i_read = 0;
        #1;
        chk_idle_outputs("fetch.after");
        tick();

        // Collision: write and fetch together
        i_read = 1; i_address = 32'h80;
        d_write = 1; d_address = 32'h100; d_wdata = 32'hDEADBEEF; d_byte_enable = 4'b0011;
        tick();
        chk("coll.mem_write", {31'b0, mem_write}, 32'h1);
        chk("coll.mem_read", {31'b0, mem_read}, 32'h0);
        chk("coll.mem_address", mem_address, 32'h100);
        chk("coll.mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("coll.mem_be", {28'b0, mem_byte_enable}, 32'h3);
        mem_resp = 1;
        #1;
        chk("coll.d_resp", {31'b0, d_resp}, 32'h1);
        chk("coll.i_resp_excl", {31'b0, i_resp}, 32'h0);
        tick();
        mem_resp = 0; d_write = 0;
        #1;
        chk_idle_outputs("coll.gap");
        tick();
        chk("coll.fetch_read", {31'b0, mem_read}, 32'h1);
        chk("coll.fetch_address", mem_address, 32'h80);
        mem_resp = 1;
        #1;
        chk("coll.fetch_i_resp", {31'b0, i_resp}, 32'h1);
        tick();
        mem_resp = 0; i_read = 0;
        tick();

        // Read+write together issues a write; dropping request keeps the grant
        d_read = 1; d_write = 1; d_address = 32'h200; d_byte_enable = 4'hF;
        tick();
        chk("rw.mem_write", {31'b0, mem_write}, 32'h1);
        chk("rw.mem_read", {31'b0, mem_read}, 32'h0);
        d_read = 0; d_write = 0;
        tick();
        chk("drop.address_held", mem_address, 32'h200);
        mem_resp = 1;
        #1;
        chk("drop.d_resp", {31'b0, d_resp}, 32'h1);
        tick();
        mem_resp = 0;
        tick();

        // Reset mid-SERVE_D aborts the write
        d_write = 1; d_address = 32'h300; d_wdata = 32'h55; d_byte_enable = 4'hF;
        tick();
        chk("abort.pre_write", {31'b0, mem_write}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("abort.in_reset");
        d_write = 0;
        tick();
        rst = 1'b0;
        mem_resp = 1;
        #1;
        chk("abort.stray_i_resp", {31'b0, i_resp}, 32'h0);
        chk("abort.stray_d_resp", {31'b0, d_resp}, 32'h0);
        tick();
        mem_resp = 0;
        #1;
        chk_idle_outputs("abort.after_stray");
        tick();

        // Three back-to-back simultaneous read pairs after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = 3'b101;
`else
        exp_d = 3'b111;
`endif
        i_read = 1; i_address = 32'hA00;
        d_read = 1; d_address = 32'hB00; d_byte_enable = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("pair%0d.address", k), mem_address, exp_d[k] ? 32'hB00 : 32'hA00);
            chk($sformatf("pair%0d.mem_read", k), {31'b0, mem_read}, 32'h1);
            mem_resp = 1;
            #1;
            chk($sformatf("pair%0d.d_resp", k), {31'b0, d_resp}, {31'b0, exp_d[k]});
            chk($sformatf("pair%0d.i_resp", k), {31'b0, i_resp}, {31'b0, ~exp_d[k]});
            tick();
            mem_resp = 0;
            #1;
            chk($sformatf("pair%0d.gap_read", k), {31'b0, mem_read}, 32'h0);
        end
        i_read = 0; d_read = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Timeout guard
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of address and data words.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports i_read in 1, i_address in DATA_W, i_rdata out DATA_W, i_resp out 1  (instruction-fetch requester, read-only).
REQ-005 SHALL have ports d_read in 1, d_write in 1, d_byte_enable in 4, d_address in DATA_W, d_wdata in DATA_W, d_rdata out DATA_W, d_resp out 1  (data requester).
REQ-006 SHALL have ports mem_read out 1, mem_write out 1, mem_byte_enable out 4, mem_address out DATA_W, mem_wdata out DATA_W, mem_rdata in DATA_W, mem_resp in 1  (shared memory port).

Function
REQ-007 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-008 IDLE: no request -> stay in IDLE; any request -> go to SERVE_I or SERVE_D next cycle per REQ-009/REQ-021.
REQ-009 SHALL apply fixed priority: data wins when d_read|d_write and i_read are both asserted in IDLE.
REQ-010 SERVE_x: SHALL drive mem_address, mem_wdata, mem_byte_enable and mem_read/mem_write from requester x's inputs; all mem_* outputs SHALL be zero in IDLE.
REQ-011 SERVE_I: mem_read=1, mem_write=0, mem_byte_enable=4'hF, mem_wdata=0.
REQ-012 SERVE_D: both d_read and d_write asserted -> write only (mem_write=1, mem_read=0).
REQ-013 Grant SHALL be held until mem_resp; other requests arriving meanwhile SHALL wait.
REQ-014 On mem_resp in SERVE_x: x_resp=1 for that same cycle only; then return to IDLE.
REQ-015 i_rdata and d_rdata SHALL both equal mem_rdata combinationally; validity is signalled only by the owning x_resp.
REQ-016 i_resp and d_resp SHALL never be asserted simultaneously; mem_resp in IDLE SHALL be ignored.
REQ-017 Requester dropping its request before mem_resp SHALL NOT release the grant; the arbiter stays in SERVE_x until mem_resp.
REQ-018 Latency: request seen in IDLE at edge N -> mem_read/mem_write asserted after edge N+1; minimum one IDLE cycle between consecutive transactions.

Reset
REQ-019 rst asserted SHALL force state to IDLE immediately, independent of clk, aborting any transaction in progress.
REQ-020 During and after reset: all mem_* outputs 0, i_resp=0, d_resp=0, round-robin pointer favors data.

Configuration
REQ-021 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, SHALL grant the requester NOT granted most recently. The last-grant pointer SHALL update on each grant and reset to "I last", so data wins first.
REQ-022 Macro ARB_ROUND_ROBIN_EN undefined: fixed data-priority per REQ-009; no pointer state.

Verification
REQ-023 Single fetch: i_read=1, i_address=32'h60, mem_resp after 3 cycles with mem_rdata=32'h00000013 -> mem_read=1, mem_address=32'h60, mem_byte_enable=4'hF; i_resp=1 one cycle, i_rdata=32'h13; d_resp=0.
REQ-024 Collision, macro undefined: i_read and d_write (addr 32'h100, wdata 32'hDEADBEEF, be 4'b0011) asserted together and held -> write served first with mem_wdata=32'hDEADBEEF, mem_byte_enable=4'b0011; fetch served after one IDLE cycle.
REQ-025 Collision, ARB_ROUND_ROBIN_EN defined: three back-to-back simultaneous i_read/d_read pairs -> grant order D, I, D.
REQ-026 d_read and d_write both asserted -> mem_write=1, mem_read=0.
REQ-027 rst pulsed mid-SERVE_D before mem_resp -> all mem_* outputs 0 within the reset cycle, no x_resp; a later stray mem_resp in IDLE produces no x_resp.
